// File: rtl/vj_uart_pkg.sv
// Shared definitions for the virtual-JTAG transmit path: frame layout and
// the data-register shifter state encoding.
package vj_uart_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned FRAME_W    = DATA_W_DEF + 1;
   localparam int unsigned VALID_BIT  = 0;

   typedef enum logic {
      IDLE,
      SHIFT
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive
// only from the count, so no input reaches them combinationally.
module sync_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_ok;
   logic              rd_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vjtag_tx_buffer.sv
// Byte transmit stage: buffers bytes from fsm_app and serializes one
// valid-flagged frame per Capture-DR onto tdo, LSB first.
module vjtag_tx_buffer
   import vj_uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     wr_en_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   input  logic                     capture_i,
   input  logic                     shift_i,
   output logic                     tdo_o,
   output logic                     busy_o
);

   localparam int unsigned FW    = DATA_W + 1;
   localparam int unsigned CNT_W = $clog2(FW + 1);

   logic [DATA_W-1:0] rd_data;
   logic [FW-1:0]     sr;
   logic [FW-1:0]     frame;
   logic [CNT_W-1:0]  bit_cnt;
   tx_state_t         state;
   tx_state_t         state_nxt;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk_i),
      .reset   (reset_i),
      .wr_data (wr_data_i),
      .wr_en   (wr_en_i),
      .rd_en   (capture_i),
      .rd_data (rd_data),
      .full    (full_o),
      .empty   (empty_o),
      .count   (count_o)
   );

   // An empty capture still produces a frame, with the valid flag clear.
   always_comb begin
      frame = '0;
      if (!empty_o) begin
         frame[FW-1:1]    = rd_data;
         frame[VALID_BIT] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         overflow_o <= 1'b0;
      end else if (wr_en_i && full_o) begin
         overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (capture_i) begin
         sr      <= frame;
         bit_cnt <= CNT_W'(FW);
      end else if (shift_i) begin
         sr <= {1'b0, sr[FW-1:1]};
         if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
   end

   assign tdo_o = sr[0];

   always_ff @(posedge clk_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (capture_i) begin
         state_nxt = SHIFT;
      end else if (shift_i && bit_cnt == CNT_W'(1)) begin
         state_nxt = IDLE;
      end
   end

   always_comb begin
      busy_o = (state == SHIFT);
   end

endmodule

// File: tb/tb_vjtag_tx_buffer.sv
// Directed bench for vjtag_tx_buffer with hand-computed frame expectations.
`timescale 1ns/1ps
module tb_vjtag_tx_buffer;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [7:0] wr_data_i;
   logic       wr_en_i;
   logic       full_o;
   logic       empty_o;
   logic [4:0] count_o;
   logic       overflow_o;
   logic       capture_i;
   logic       shift_i;
   logic       tdo_o;
   logic       busy_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   vjtag_tx_buffer #(
      .DEPTH  (16),
      .DATA_W (8)
   ) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .wr_data_i  (wr_data_i),
      .wr_en_i    (wr_en_i),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .count_o    (count_o),
      .overflow_o (overflow_o),
      .capture_i  (capture_i),
      .shift_i    (shift_i),
      .tdo_o      (tdo_o),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr_data_i = d;
      wr_en_i   = 1'b1;
      tick();
      wr_en_i   = 1'b0;
   endtask

   // Capture (optionally with a coincident shift), collect 9 bits, finish the frame.
   task automatic read_frame(input logic also_shift, output logic [8:0] f);
      capture_i = 1'b1;
      shift_i   = also_shift;
      tick();
      capture_i = 1'b0;
      shift_i   = 1'b0;
      f[0] = tdo_o;
      for (int i = 1; i < 9; i++) begin
         shift_i = 1'b1;
         tick();
         f[i] = tdo_o;
      end
      check("busy_before_last_shift", busy_o, 1);
      tick();
      shift_i = 1'b0;
      check("busy_after_frame", busy_o, 0);
   endtask

   logic [8:0] f;
   logic [7:0] d;
   logic [8:0] seq_a5;

   initial begin
      reset_i   = 1'b1;
      wr_data_i = '0;
      wr_en_i   = 1'b0;
      capture_i = 1'b0;
      shift_i   = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      check("rst_count", count_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_overflow", overflow_o, 0);
      check("rst_tdo", tdo_o, 0);
      check("rst_busy", busy_o, 0);

      // Empty capture: all-zero frame, busy for exactly 9 shifts.
      read_frame(1'b0, f);
      check("empty_frame", f, 9'h000);
      check("empty_stays", empty_o, 1);

      // 0xA5 -> bits 1,1,0,1,0,0,1,0,1 (bit0 first) = 9'b1_0100_1011
      write_byte(8'hA5);
      check("a5_count1", count_o, 1);
      seq_a5 = 9'b101001011;
      read_frame(1'b0, f);
      check("a5_frame", f, seq_a5);
      check("a5_count0", count_o, 0);

      // Fill past capacity
      wr_en_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr_data_i = 8'(i);
         tick();
         if (i == 15) begin
            check("full_at_16", full_o, 1);
            check("no_ovf_at_16", overflow_o, 0);
         end
      end
      wr_en_i = 1'b0;
      check("overflow_set", overflow_o, 1);
      check("count_16", count_o, 16);
      for (int i = 0; i < 16; i++) begin
         read_frame(1'b0, f);
         check("fill_frame", f, {8'(i), 1'b1});
      end
      read_frame(1'b0, f);
      check("frame17_invalid", f, 9'h000);
      check("drain_empty", empty_o, 1);
      check("overflow_sticky", overflow_o, 1);

      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("ovf_cleared", overflow_o, 0);

      // Write and capture together on empty FIFO
      wr_data_i = 8'h3C;
      wr_en_i   = 1'b1;
      capture_i = 1'b1;
      tick();
      wr_en_i   = 1'b0;
      capture_i = 1'b0;
      check("wc_valid0", tdo_o, 0);
      check("wc_count1", count_o, 1);
      read_frame(1'b0, f);
      check("wc_frame", f, {8'h3C, 1'b1});

      // Capture+shift mid-frame: capture wins, counter reloads to 9
      write_byte(8'h11);
      write_byte(8'h22);
      capture_i = 1'b1;
      tick();
      capture_i = 1'b0;
      check("mid_first_valid", tdo_o, 1);
      shift_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("mid_bit4", tdo_o, 1'b0);
      read_frame(1'b1, f);
      check("mid_new_frame", f, {8'h22, 1'b1});
      check("mid_count0", count_o, 0);

      // Wrap-around through interleaved write/read
      for (int i = 0; i < 40; i++) begin
         d = 8'((i * 37 + 5) & 8'hFF);
         write_byte(d);
         check("wrap_count", count_o, 1);
         read_frame(1'b0, f);
         check("wrap_frame", f, {d, 1'b1});
      end
      check("wrap_no_ovf", overflow_o, 0);
      check("wrap_empty", empty_o, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vjtag_tx_buffer.md
Name: vjtag_tx_buffer

Overview:
- Byte transmit stage directly downstream of fsm_app.
- fsm_app pushes bytes into a small synchronous FIFO.
- The virtual-JTAG data-register side drains the FIFO one frame per Capture-DR and serializes the frame on Shift-DR pulses.
- Frame is 9 bits, LSB first: bit0 = valid flag, bits8:1 = data byte. This lets the host tell real data from an empty poll.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
DATA_W, 8, payload width; frame width = DATA_W+1.

Ports:
clk_i  in  1  system clock (sysclk from pll_clock)
reset_i  in  1  synchronous reset, active-high
wr_data_i  in  DATA_W  byte from fsm_app
wr_en_i  in  1  write strobe, one byte per asserted cycle
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a write was dropped
capture_i  in  1  single-cycle Capture-DR pulse, already synchronized to clk_i
shift_i  in  1  single-cycle Shift-DR pulse, already synchronized to clk_i
tdo_o  out  1  serial frame bit = sr[0]
busy_o  out  1  frame bits still unshifted

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values (applied at the first clk_i edge with reset_i=1): pointers 0; count_o=0; empty_o=1; full_o=0; overflow_o=0; sr=0; tdo_o=0; bit_cnt=0; busy_o=0; FSM in IDLE.
- Reset mid-frame: the frame is abandoned, not re-queued. Reset mid-write: the byte is discarded.
- Write:
  - wr_en_i && !full_o: store at wr_ptr, wr_ptr+1 (mod DEPTH), count+1.
  - Data becomes visible to a capture on the next cycle. Zero bypass.
- Write when full:
  - Byte dropped; overflow_o <= 1; it stays set until reset.
  - full_o is judged on registered state: a write in the same cycle as a pop from full is still dropped.
- Capture (capture_i=1):
  - If !empty_o: sr <= {mem[rd_ptr],1'b1}; rd_ptr+1; count-1.
  - If empty_o: sr <= 0 (valid=0); nothing popped.
  - Either case: bit_cnt <= DATA_W+1 and FSM -> SHIFT.
  - Capture in any state reloads the frame. A partially shifted frame is lost, and its byte was already popped.
- Shift (shift_i=1, capture_i=0):
  - sr <= {1'b0, sr[DATA_W:1]}.
  - If bit_cnt>0, bit_cnt-1; reaching 0 -> IDLE.
  - Shifts in IDLE keep shifting zeros; tdo_o=0.
- Priority: capture_i beats shift_i in the same cycle.
- Simultaneous write and capture:
  - Non-empty: both happen; count unchanged.
  - Empty: capture sees empty and loads valid=0; the write lands normally (count=1 next cycle).
- FSM: IDLE (busy_o=0) <-> SHIFT (busy_o=1, bit_cnt != 0). Transitions only as above.
- Pointer and flag arithmetic:
  - Pointers are $clog2(DEPTH) bits, wrap naturally.
  - count is one bit wider.
  - full_o = (count==DEPTH); empty_o = (count==0). Both registered-derived, no combinational path from inputs.
- Latency: write to earliest capture = 1 cycle. Capture to first valid tdo_o = next cycle (tdo_o = sr[0], registered).

Decomposition:
- Package vj_uart_pkg holds FRAME_W = DATA_W+1, VALID_BIT = 0, and the FSM state enum {IDLE, SHIFT}. Shared with the host-side frame decoder and fsm_app.
- One sub-module, sync_fifo (DEPTH, DATA_W): storage, pointers, count, full/empty.
- Top-level vjtag_tx_buffer keeps the overflow flag, shift register, bit counter and FSM.

Test Plan:
- Reset, then capture on empty + 9 shifts -> tdo_o sequence all 0; busy_o 1 for 9 shifts then 0; empty_o stays 1.
- Write 0xA5, capture next cycle, 9 shifts -> tdo_o = 1,1,0,1,0,0,1,0,1 (valid then 0xA5 LSB first); count_o 1->0.
- Write 17 bytes 0x00..0x10 back-to-back with DEPTH=16:
  - full_o=1 after the 16th write; 0x10 dropped; overflow_o=1.
  - 16 capture/shift frames return 0x00..0x0F in order.
  - The 17th frame has valid=0.
- Write and capture in the same cycle on an empty FIFO:
  - Captured frame has valid=0; count_o=1 next cycle.
  - The following capture returns the written byte.
- Capture and shift pulsed together mid-frame (after 4 shifts) -> capture wins; bit_cnt reloads to 9; new byte popped; remaining bits of the old frame lost.
- Wrap-around: 40 interleaved write/capture pairs with varying data -> all 40 bytes returned in order; count_o never exceeds 1; overflow_o stays 0.
